slave_split_ctrl: RTL and testbench

SLAVE_SPLIT_CTRL -- requirements
Module: slave_split_ctrl

---
 rtl/sys_bus_pkg.sv | 24 ++
 rtl/split_timer.sv | 39 +++
 rtl/slave_split_ctrl.sv | 151 +++++++++++++++
 tb/tb_slave_split_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_bus_pkg.sv
// Shared bus definitions: controller state encoding, master one-hot codes
// and the default split threshold used by the slave split controller.
package sys_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ACCESS     = 3'd1,
    ST_SPLIT_WAIT = 3'd2,
    ST_REGRANT    = 3'd3,
    ST_RESUME     = 3'd4
  } state_t;

  localparam logic [1:0] M1   = 2'b10;
  localparam logic [1:0] M2   = 2'b01;
  localparam logic [1:0] NONE = 2'b00;

  localparam int DEF_SPLIT_THRESHOLD = 4;

  // A grant is usable only when exactly one master is named.
  function automatic logic is_one_hot2(input logic [1:0] g);
    return (g == M1) || (g == M2);
  endfunction

endpackage

// File: rtl/split_timer.sv
// Saturating 4-bit wait counter for the slave split controller.
// hit_o flags the enabled cycle whose increment brings the count to THRESHOLD.
module split_timer #(
  parameter int THRESHOLD = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic hit_o
);

  localparam logic [3:0] HIT_AT = 4'(THRESHOLD - 1);

  logic [3:0] count_q;
  logic [3:0] count_d;

  // Clear wins over enable; the count holds at 15 instead of wrapping.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = 4'd0;
    end else if (enable_i && (count_q != 4'hF)) begin
      count_d = count_q + 4'd1;
    end
  end

  // Count register, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= 4'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign hit_o = enable_i && !clear_i && (count_q == HIT_AT);

endmodule

// File: rtl/slave_split_ctrl.sv
// Slave-side split transaction controller. Accepts a transaction from the
// granted master, starts the slave core, and if the core is slow splits the
// transaction, later requesting a re-grant for the original owner.
module slave_split_ctrl
  import sys_bus_pkg::*;
#(
  parameter int SPLIT_THRESHOLD = DEF_SPLIT_THRESHOLD
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] gmaster,
  input  logic [1:0] bus_utilization,
  input  logic       txn_valid,
  input  logic       mem_ready,
  output logic       mem_start,
  output logic       split_resp,
  output logic [1:0] split_req,
  output logic       done,
  output logic       retry,
  output logic       busy
);

  state_t     state_q, state_d;
  logic [1:0] owner_q, owner_d;

  logic       mem_start_q, mem_start_d;
  logic       split_resp_q, split_resp_d;
  logic [1:0] split_req_q, split_req_d;
  logic       done_q, done_d;
  logic       retry_q, retry_d;
  logic       busy_q, busy_d;

  logic       tmr_clear;
  logic       tmr_en;
  logic       tmr_hit;

  // Bus-in-use flags are informational for this slave; no decision uses them.
  logic       bus_util_unused;
  assign bus_util_unused = ^bus_utilization;

  split_timer #(
    .THRESHOLD (SPLIT_THRESHOLD)
  ) u_split_timer (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (tmr_clear),
    .enable_i (tmr_en),
    .hit_o    (tmr_hit)
  );

  // Next-state and next-output logic; every output is a one-cycle pulse
  // except split_req (held through REGRANT) and busy.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    mem_start_d  = 1'b0;
    split_resp_d = 1'b0;
    split_req_d  = NONE;
    done_d       = 1'b0;
    retry_d      = 1'b0;
    tmr_clear    = 1'b0;
    tmr_en       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (txn_valid) begin
          if (is_one_hot2(gmaster)) begin
            owner_d     = gmaster;
            mem_start_d = 1'b1;
            tmr_clear   = 1'b1;
            state_d     = ST_ACCESS;
          end else begin
            retry_d = 1'b1;
          end
        end
      end
      ST_ACCESS: begin
        // A ready core always beats the split decision in the same cycle.
        if (mem_ready) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmr_en = 1'b1;
          if (tmr_hit) begin
            split_resp_d = 1'b1;
            state_d      = ST_SPLIT_WAIT;
          end
        end
      end
      ST_SPLIT_WAIT: begin
        if (mem_ready) begin
          split_req_d = owner_q;
          state_d     = ST_REGRANT;
        end
      end
      ST_REGRANT: begin
        // No timeout: keep asking until the owner itself is granted.
        if (gmaster == owner_q) begin
          state_d = ST_RESUME;
        end else begin
          split_req_d = owner_q;
        end
      end
      ST_RESUME: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Any transaction arriving while busy is bounced without side effects.
    if ((state_q != ST_IDLE) && txn_valid) begin
      retry_d = 1'b1;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State, owner and registered outputs; reset clears all of them at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= NONE;
      mem_start_q  <= 1'b0;
      split_resp_q <= 1'b0;
      split_req_q  <= NONE;
      done_q       <= 1'b0;
      retry_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      mem_start_q  <= mem_start_d;
      split_resp_q <= split_resp_d;
      split_req_q  <= split_req_d;
      done_q       <= done_d;
      retry_q      <= retry_d;
      busy_q       <= busy_d;
    end
  end

  assign mem_start  = mem_start_q;
  assign split_resp = split_resp_q;
  assign split_req  = split_req_q;
  assign done       = done_q;
  assign retry      = retry_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_slave_split_ctrl.sv
// Testbench for slave_split_ctrl: each transaction's expected output timeline
// is derived from its timing parameters (ready cycle, grant cycle, probe cycle).
module tb_slave_split_ctrl;

  localparam int THR = 4;
  localparam logic [1:0] TB_M1 = 2'b10;
  localparam logic [1:0] TB_M2 = 2'b01;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] gmaster = 2'b00;
  logic [1:0] bus_utilization = 2'b00;
  logic       txn_valid = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_start, split_resp, done, retry, busy;
  logic [1:0] split_req;

  int errors = 0;
  int checks = 0;

  // Per-sample vectors: {mem_start, split_resp, split_req[1:0], done, retry, busy}
  logic [6:0] exp_v [32];
  logic [6:0] obs_v [32];
  int         nsamp;

  slave_split_ctrl #(.SPLIT_THRESHOLD(THR)) dut (
    .clk             (clk),
    .reset           (reset),
    .gmaster         (gmaster),
    .bus_utilization (bus_utilization),
    .txn_valid       (txn_valid),
    .mem_ready       (mem_ready),
    .mem_start       (mem_start),
    .split_resp      (split_resp),
    .split_req       (split_req),
    .done            (done),
    .retry           (retry),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] outs();
    return {mem_start, split_resp, split_req, done, retry, busy};
  endfunction

  // Transaction accepted at edge 0; mem_ready first high at edge r; owner
  // granted at edge g (split case). Completion sample index.
  function automatic int txn_len(input int r, input int g);
    return (r <= THR) ? r : g + 1;
  endfunction

  // Reference timeline: start at 0, split at THR if the core is still not
  // ready, re-grant request from r until the grant edge g, done at the end.
  task automatic model_txn(input logic [1:0] m, input int r, input int g, input int probe);
    bit         split;
    int         d;
    logic [1:0] sq;
    split = (r > THR);
    d     = txn_len(r, g);
    nsamp = d + 1;
    for (int k = 0; k <= d; k++) begin
      sq = (split && k >= r && k < g) ? m : 2'b00;
      exp_v[k] = {(k == 0), (split && k == THR), sq, (k == d),
                  (probe > 0 && k == probe), (k < d)};
    end
  endtask

  function automatic logic [1:0] pick_nonowner(input logic [1:0] m);
    int sel;
    sel = $urandom_range(0, 2);
    if (sel == 0) return 2'b00;
    if (sel == 1) return ~m;
    return 2'b11;
  endfunction

  // Drives one transaction over nsamp edges and records outputs #1 after each.
  task automatic drive_txn(input logic [1:0] m, input int r, input int g,
                           input int probe, input bit fixed_other);
    for (int k = 0; k < nsamp; k++) begin
      txn_valid = (k == 0) || (probe > 0 && k == probe);
      mem_ready = (k >= r);
      if (k == 0 || k == g) gmaster = m;
      else gmaster = fixed_other ? ~m : pick_nonowner(m);
      bus_utilization = 2'($urandom_range(0, 3));
      @(posedge clk);
      #1;
      obs_v[k] = outs();
    end
    txn_valid = 1'b0;
    mem_ready = 1'b0;
    gmaster   = 2'b00;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (outs() !== 7'b0) begin
      errors++;
      $display("FAIL reset_state got=%b want=%b", outs(), 7'b0);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  // First transaction right after reset release; core ready two cycles later.
  task automatic test_direct();
    model_txn(TB_M1, 2, -1, 0);
    drive_txn(TB_M1, 2, -1, 0, 1'b0);
    for (int k = 0; k < nsamp; k++) begin
      checks++;
      if (obs_v[k] !== exp_v[k]) begin
        errors++;
        $display("FAIL direct cyc%0d got=%b want=%b", k, obs_v[k], exp_v[k]);
      end
    end
  endtask

  task automatic test_split();
    model_txn(TB_M2, 11, 13, 0);
    drive_txn(TB_M2, 11, 13, 0, 1'b0);
    for (int k = 0; k < nsamp; k++) begin
      checks++;
      if (obs_v[k] !== exp_v[k]) begin
        errors++;
        $display("FAIL split cyc%0d got=%b want=%b", k, obs_v[k], exp_v[k]);
      end
    end
  endtask

  // Other master granted for 5 cycles in REGRANT before the owner.
  task automatic test_regrant_hold();
    model_txn(TB_M2, 5, 11, 0);
    drive_txn(TB_M2, 5, 11, 0, 1'b1);
    for (int k = 0; k < nsamp; k++) begin
      checks++;
      if (obs_v[k] !== exp_v[k]) begin
        errors++;
        $display("FAIL regrant_hold cyc%0d got=%b want=%b", k, obs_v[k], exp_v[k]);
      end
    end
  endtask

  // Core ready on exactly the cycle the count reaches the threshold.
  task automatic test_threshold_race();
    model_txn(TB_M1, THR, -1, 0);
    drive_txn(TB_M1, THR, -1, 0, 1'b0);
    for (int k = 0; k < nsamp; k++) begin
      checks++;
      if (obs_v[k] !== exp_v[k]) begin
        errors++;
        $display("FAIL threshold_race cyc%0d got=%b want=%b", k, obs_v[k], exp_v[k]);
      end
    end
  endtask

  // Foreign transaction during SPLIT_WAIT from the other master.
  task automatic test_retry_busy();
    model_txn(TB_M1, 8, 10, 6);
    drive_txn(TB_M1, 8, 10, 6, 1'b1);
    for (int k = 0; k < nsamp; k++) begin
      checks++;
      if (obs_v[k] !== exp_v[k]) begin
        errors++;
        $display("FAIL retry_busy cyc%0d got=%b want=%b", k, obs_v[k], exp_v[k]);
      end
    end
  endtask

  task automatic test_bad_grant();
    logic [1:0] g;
    for (int i = 0; i < 2; i++) begin
      g = (i == 0) ? 2'b11 : 2'b00;
      txn_valid = 1'b1;
      gmaster   = g;
      @(posedge clk);
      #1;
      checks++;
      if (outs() !== 7'b0000010) begin
        errors++;
        $display("FAIL bad_grant_%b got=%b want=%b", g, outs(), 7'b0000010);
      end
      txn_valid = 1'b0;
      gmaster   = 2'b00;
      @(posedge clk);
      #1;
      checks++;
      if (outs() !== 7'b0) begin
        errors++;
        $display("FAIL bad_grant_idle_%b got=%b want=%b", g, outs(), 7'b0);
      end
    end
  endtask

  task automatic test_reset_mid_split();
    txn_valid = 1'b1;
    gmaster   = TB_M1;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    txn_valid = 1'b0;
    gmaster   = TB_M2;
    repeat (THR) @(posedge clk);
    #1;
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({split_req, busy} !== {TB_M1, 1'b1}) begin
      errors++;
      $display("FAIL pre_reset_regrant got=%b want=%b", {split_req, busy}, {TB_M1, 1'b1});
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (outs() !== 7'b0) begin
      errors++;
      $display("FAIL async_reset got=%b want=%b", outs(), 7'b0);
    end
    mem_ready = 1'b0;
    gmaster   = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (outs() !== 7'b0) begin
      errors++;
      $display("FAIL reset_held got=%b want=%b", outs(), 7'b0);
    end
    @(negedge clk);
    reset = 1'b1;
    model_txn(TB_M2, 3, -1, 0);
    drive_txn(TB_M2, 3, -1, 0, 1'b0);
    for (int k = 0; k < nsamp; k++) begin
      checks++;
      if (obs_v[k] !== exp_v[k]) begin
        errors++;
        $display("FAIL post_reset cyc%0d got=%b want=%b", k, obs_v[k], exp_v[k]);
      end
    end
  endtask

  // Back-to-back random transactions with optional busy-time probes.
  task automatic test_random();
    logic [1:0] m;
    int r, g, d, probe;
    for (int t = 0; t < 25; t++) begin
      m = ($urandom_range(0, 1) == 0) ? TB_M1 : TB_M2;
      r = $urandom_range(1, 10);
      g = r + $urandom_range(1, 6);
      d = txn_len(r, g);
      probe = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, d);
      model_txn(m, r, g, probe);
      drive_txn(m, r, g, probe, 1'b0);
      for (int k = 0; k < nsamp; k++) begin
        checks++;
        if (obs_v[k] !== exp_v[k]) begin
          errors++;
          $display("FAIL random t%0d(r=%0d g=%0d p=%0d) cyc%0d got=%b want=%b",
                   t, r, g, probe, k, obs_v[k], exp_v[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_direct();
    test_split();
    test_regrant_hold();
    test_threshold_race();
    test_retry_busy();
    test_bad_grant();
    test_reset_mid_split();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
